// File: rtl/fir4_mac_datapath_if.sv
// rtl/fir4_mac_datapath_if.sv - sequencer/datapath bus for the 4-tap FIR MAC; sat_flag exists only with FIR_SAT_EN
interface fir4_mac_datapath_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
);
    logic signed [DATA_W-1:0] sample_in;
    logic        [1:0]        mux_sel;
    logic                     data_strobe;
    logic                     clear_accum;
    logic                     coef_we;
    logic        [1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [OUT_W-1:0]  y_out;
    logic                     y_valid;
`ifdef FIR_SAT_EN
    logic                     sat_flag;

    modport master (
        output sample_in, mux_sel, data_strobe, clear_accum, coef_we, coef_addr, coef_data,
        input  y_out, y_valid, sat_flag
    );
    modport slave (
        input  sample_in, mux_sel, data_strobe, clear_accum, coef_we, coef_addr, coef_data,
        output y_out, y_valid, sat_flag
    );
`else
    modport master (
        output sample_in, mux_sel, data_strobe, clear_accum, coef_we, coef_addr, coef_data,
        input  y_out, y_valid
    );
    modport slave (
        input  sample_in, mux_sel, data_strobe, clear_accum, coef_we, coef_addr, coef_data,
        output y_out, y_valid
    );
`endif
endinterface

// File: rtl/fir4_mac_datapath.sv
// rtl/fir4_mac_datapath.sv - serial 4-tap signed FIR MAC datapath; FIR_SAT_EN selects saturating output
module fir4_mac_datapath #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = DATA_W + COEF_W + 2,
    parameter int OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       Reset,
    fir4_mac_datapath_if.slave         bus
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [DATA_W-1:0] x_q [4];
    logic signed [DATA_W-1:0] x_d [4];
    logic signed [COEF_W-1:0] c_q [4];
    logic signed [COEF_W-1:0] c_d [4];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  y_q, y_d;
    logic                     y_valid_q, y_valid_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [OUT_W-1:0]  conv;
`ifdef FIR_SAT_EN
    logic                     sat_q, sat_d;
    logic [ACC_W-OUT_W:0]     upper;
    logic                     clip;
`endif

    always_comb begin
        prod = PROD_W'(x_q[bus.mux_sel]) * PROD_W'(c_q[bus.mux_sel]);
        sum  = acc_q + ACC_W'(prod);
`ifdef FIR_SAT_EN
        // Output fits only when every bit above the output sign bit matches it.
        upper = sum[ACC_W-1:OUT_W-1];
        clip  = !((&upper) || !(|upper));
        if (!clip)
            conv = sum[OUT_W-1:0];
        else if (sum[ACC_W-1])
            conv = {1'b1, {(OUT_W-1){1'b0}}};
        else
            conv = {1'b0, {(OUT_W-1){1'b1}}};
`else
        conv = OUT_W'(sum);
`endif
    end

    always_comb begin
        x_d       = x_q;
        c_d       = c_q;
        y_d       = y_q;
        y_valid_d = bus.data_strobe;
        acc_d     = bus.clear_accum ? '0 : sum;
`ifdef FIR_SAT_EN
        sat_d     = sat_q;
`endif
        // The product above already read c_q, so a same-cycle write only lands next cycle.
        if (bus.coef_we)
            c_d[bus.coef_addr] = bus.coef_data;
        if (bus.data_strobe) begin
            y_d    = conv;
            x_d[3] = x_q[2];
            x_d[2] = x_q[1];
            x_d[1] = x_q[0];
            x_d[0] = bus.sample_in;
`ifdef FIR_SAT_EN
            sat_d  = clip;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            x_q       <= '{default: '0};
            c_q       <= '{default: '0};
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
`ifdef FIR_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            x_q       <= x_d;
            c_q       <= c_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
`ifdef FIR_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign bus.y_out   = y_q;
    assign bus.y_valid = y_valid_q;
`ifdef FIR_SAT_EN
    assign bus.sat_flag = sat_q;
`endif
endmodule

// File: tb/tb_fir4_mac_datapath.sv
// tb/tb_fir4_mac_datapath.sv - randomized and directed bench for fir4_mac_datapath against an integer model
module tb_fir4_mac_datapath;
    logic clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;

    fir4_mac_datapath_if #(.DATA_W(8), .COEF_W(8), .OUT_W(16)) bus ();

    fir4_mac_datapath #(.DATA_W(8), .COEF_W(8), .ACC_W(18), .OUT_W(16)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int      mx [4];
    int      mc [4];
    longint  macc;
    longint  my;
    bit      mvalid;
    bit      msat;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) <<< w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic model_step(input bit rst, input int sel, input bit stb, input bit clr,
                              input bit we, input int addr, input int cdat, input int smp);
        longint sum;
        if (rst) begin
            mx = '{0, 0, 0, 0};
            mc = '{0, 0, 0, 0};
            macc = 0; my = 0; mvalid = 0; msat = 0;
            return;
        end
        sum  = wrapw(macc + longint'(mx[sel]) * longint'(mc[sel]), 18);
        macc = clr ? 0 : sum;
        mvalid = stb;
        if (stb) begin
`ifdef FIR_SAT_EN
            if (sum > 32767)       begin my = 32767;  msat = 1; end
            else if (sum < -32768) begin my = -32768; msat = 1; end
            else                   begin my = sum;    msat = 0; end
`else
            my = wrapw(sum, 16);
`endif
            mx[3] = mx[2]; mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = smp;
        end
        if (we) mc[addr] = cdat;
    endtask

    task automatic cyc(input bit rst, input int sel, input bit stb, input bit clr,
                       input bit we, input int addr, input int cdat, input int smp);
        logic [1:0] sel_v;
        logic [1:0] addr_v;
        logic [7:0] cdat_v;
        logic [7:0] smp_v;
        sel_v  = sel[1:0];
        addr_v = addr[1:0];
        cdat_v = cdat[7:0];
        smp_v  = smp[7:0];
        Reset           = rst;
        bus.mux_sel     = sel_v;
        bus.data_strobe = stb;
        bus.clear_accum = clr;
        bus.coef_we     = we;
        bus.coef_addr   = addr_v;
        bus.coef_data   = cdat_v;
        bus.sample_in   = smp_v;
        @(posedge clk);
        model_step(rst, sel, stb, clr, we, addr, cdat, smp);
        #1;
        check("y_out", longint'($signed(bus.y_out)), my);
        check("y_valid", longint'(bus.y_valid), longint'(mvalid));
`ifdef FIR_SAT_EN
        check("sat_flag", longint'(bus.sat_flag), longint'(msat));
`endif
    endtask

    task automatic frame(input int smp);
        for (int s = 0; s < 4; s++)
            cyc(0, s, s == 3, s == 3, 0, 0, 0, smp);
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
        int cv [4];
        cv = '{c0, c1, c2, c3};
        for (int a = 0; a < 4; a++)
            cyc(0, a, 0, 1, 1, a, cv[a], 0);
    endtask

    initial begin
        int step_exp [6];
        step_exp = '{0, 10, 30, 60, 100, 100};

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            cyc(1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255) - 128,
                $urandom_range(0, 255) - 128);
        check("rst_y_out", longint'($signed(bus.y_out)), 0);
        check("rst_y_valid", longint'(bus.y_valid), 0);
        frame(0);
        check("rst_taps_zero", longint'($signed(bus.y_out)), 0);

        // Step response
        load_coefs(1, 2, 3, 4);
        for (int f = 0; f < 6; f++) begin
            frame(10);
            check("step_y", longint'($signed(bus.y_out)), step_exp[f]);
            check("step_valid", longint'(bus.y_valid), 1);
            @(negedge clk);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("valid_one_cycle", longint'(bus.y_valid), 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);

        // Coefficient write in use: old c2 this frame, new c2 next
        cyc(0, 0, 0, 0, 0, 0, 0, 10);
        cyc(0, 1, 0, 0, 0, 0, 0, 10);
        cyc(0, 2, 0, 0, 1, 2, 5, 10);
        cyc(0, 3, 1, 1, 0, 0, 0, 10);
        check("coef_old", longint'($signed(bus.y_out)), 100);
        frame(10);
        check("coef_new", longint'($signed(bus.y_out)), 120);

        // Stray clear at sel=1
        cyc(0, 0, 0, 0, 0, 0, 0, 10);
        cyc(0, 1, 0, 1, 0, 0, 0, 10);
        check("stray_hold", longint'($signed(bus.y_out)), 120);
        cyc(0, 2, 0, 0, 0, 0, 0, 10);
        cyc(0, 3, 1, 1, 0, 0, 0, 10);
        check("stray_partial", longint'($signed(bus.y_out)), 90);

        // Reset mid-frame
        cyc(0, 0, 0, 0, 0, 0, 0, 10);
        cyc(0, 1, 0, 0, 0, 0, 0, 10);
        cyc(1, 2, 0, 0, 0, 0, 0, 10);
        cyc(0, 3, 1, 1, 0, 0, 0, 10);
        check("midreset_y", longint'($signed(bus.y_out)), 0);

        // Max positive
        load_coefs(127, 127, 127, 127);
        for (int f = 0; f < 5; f++) frame(127);
`ifdef FIR_SAT_EN
        check("sat_pos_y", longint'($signed(bus.y_out)), 32767);
        check("sat_pos_flag", longint'(bus.sat_flag), 1);
`else
        check("wrap_pos_y", longint'($signed(bus.y_out)), -1020);
`endif

        // Max negative
        for (int f = 0; f < 5; f++) frame(-128);
`ifdef FIR_SAT_EN
        check("sat_neg_y", longint'($signed(bus.y_out)), -32768);
        check("sat_neg_flag", longint'(bus.sat_flag), 1);
`else
        check("wrap_neg_y", longint'($signed(bus.y_out)), 512);
`endif

        // Random traffic, including misuse and occasional reset
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);

        // Random full frames with large values to stress conversion
        for (int i = 0; i < 40; i++) begin
            cyc(0, $urandom_range(0, 3), 0, 0, 1, $urandom_range(0, 3),
                $urandom_range(0, 1) ? 127 : -128, 0);
            frame($urandom_range(0, 1) ? 127 : -128);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
